// File: rtl/spi_reg_access_if.sv
// spi_reg_access_if: SPI pins plus register-bank bus for spi_reg_access
//   SPI_NSS_IN/SPI_SCLK_IN/SPI_MOSI_IN  async SPI inputs (mode 0, NSS active-low)
//   SPI_MISO_OUT                        serial read data, MSB first
//   WRITE_OUT/ADDR_OUT/WRITE_DATA_OUT   register write strobe, address, data
//   READ_DATA_IN                        combinational read data for ADDR_OUT
//   BUSY_OUT/ABORT_COUNT_OUT            frame in progress, saturating abort count
interface spi_reg_access_if #(
   parameter int REGA_BITS = 14,
   parameter int REGD_BITS = 32
);
   logic                 SPI_NSS_IN;
   logic                 SPI_SCLK_IN;
   logic                 SPI_MOSI_IN;
   logic                 SPI_MISO_OUT;
   logic                 WRITE_OUT;
   logic [REGA_BITS-1:0] ADDR_OUT;
   logic [REGD_BITS-1:0] WRITE_DATA_OUT;
   logic [REGD_BITS-1:0] READ_DATA_IN;
   logic                 BUSY_OUT;
   logic [7:0]           ABORT_COUNT_OUT;
   modport slave (
      input  SPI_NSS_IN, SPI_SCLK_IN, SPI_MOSI_IN, READ_DATA_IN,
      output SPI_MISO_OUT, WRITE_OUT, ADDR_OUT, WRITE_DATA_OUT, BUSY_OUT, ABORT_COUNT_OUT
   );
   modport master (
      output SPI_NSS_IN, SPI_SCLK_IN, SPI_MOSI_IN, READ_DATA_IN,
      input  SPI_MISO_OUT, WRITE_OUT, ADDR_OUT, WRITE_DATA_OUT, BUSY_OUT, ABORT_COUNT_OUT
   );
endinterface

// File: rtl/spi_reg_access.sv
// spi_reg_access: oversampled SPI slave issuing single-cycle register reads/writes
//   CLK_IN    system clock (>= 8x SCLK)
//   RESET_IN  synchronous active-high reset
//   bus       spi_reg_access_if.slave: SPI pins and register-bank bus
module spi_reg_access #(
   parameter int REGA_BITS = 14,
   parameter int REGD_BITS = 32
) (
   input logic             CLK_IN,
   input logic             RESET_IN,
   spi_reg_access_if.slave bus
);
   localparam int CW = $clog2(REGD_BITS + 16);
   typedef enum logic [2:0] {IDLE, HDR, LOAD, DATA, DONE} state_t;
   state_t               state_q, state_d;
   logic [1:0]           nss_q, mosi_q, vld_q;
   logic [2:0]           sclk_q;
   logic                 arm_q, arm_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [REGA_BITS-2:0] hdr_q, hdr_d;
   logic [REGA_BITS-1:0] hdr_n;
   logic                 w_q, w_d;
   logic [REGA_BITS-1:0] addr_q, addr_d;
   logic [REGD_BITS-1:0] wdata_q, wdata_d, rdsh_q, rdsh_d;
   logic                 miso_q, miso_d, write_q, write_d;
   logic [7:0]           abort_q, abort_d;
   logic                 nss_s, mosi_s, rise, fall, last, busy;
   assign nss_s  = nss_q[1];
   assign mosi_s = mosi_q[1];
   assign rise   = sclk_q[1] & ~sclk_q[2];
   assign fall   = ~sclk_q[1] & sclk_q[2];
   // Only the low REGA_BITS header bits survive the shift; W is captured on the first rise.
   assign hdr_n  = {hdr_q, mosi_s};
   assign last   = cnt_q == CW'(REGD_BITS - 1);
   assign busy   = state_q == HDR || state_q == LOAD || state_q == DATA;
   always_ff @(posedge CLK_IN) begin
      if (RESET_IN) begin
         nss_q   <= '1;
         sclk_q  <= '0;
         mosi_q  <= '0;
         vld_q   <= '0;
         arm_q   <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= '0;
         hdr_q   <= '0;
         w_q     <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdsh_q  <= '0;
         miso_q  <= 1'b0;
         write_q <= 1'b0;
         abort_q <= '0;
      end else begin
         nss_q   <= {nss_q[0], bus.SPI_NSS_IN};
         sclk_q  <= {sclk_q[1:0], bus.SPI_SCLK_IN};
         mosi_q  <= {mosi_q[0], bus.SPI_MOSI_IN};
         vld_q   <= {vld_q[0], 1'b1};
         arm_q   <= arm_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hdr_q   <= hdr_d;
         w_q     <= w_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdsh_q  <= rdsh_d;
         miso_q  <= miso_d;
         write_q <= write_d;
         abort_q <= abort_d;
      end
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hdr_d   = hdr_q;
      w_d     = w_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdsh_d  = rdsh_q;
      miso_d  = miso_q;
      write_d = 1'b0;
      abort_d = abort_q;
      // Arm only once the synchroniser has refilled from the pin after reset and NSS is
      // seen high, so a frame already running at reset release is ignored.
      arm_d   = arm_q | (vld_q[1] & nss_s);
      case (state_q)
         IDLE: begin
            miso_d = 1'b0;
            if (arm_q && !nss_s) begin
               cnt_d   = '0;
               state_d = HDR;
            end
         end
         HDR: if (rise) begin
            hdr_d = hdr_n[REGA_BITS-2:0];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == '0) w_d = mosi_s;
            if (cnt_q == CW'(15)) begin
               addr_d  = hdr_n;
               cnt_d   = '0;
               state_d = w_q ? DATA : LOAD;
            end
         end
         LOAD: begin
            rdsh_d  = bus.READ_DATA_IN;
            state_d = DATA;
         end
         DATA: begin
            if (rise) begin
               cnt_d = cnt_q + CW'(1);
               if (w_q) wdata_d = {wdata_q[REGD_BITS-2:0], mosi_s};
               if (last) begin
                  state_d = DONE;
                  write_d = w_q;
               end
            end
            if (fall && !w_q) begin
               miso_d = rdsh_q[REGD_BITS-1];
               rdsh_d = {rdsh_q[REGD_BITS-2:0], 1'b0};
            end
         end
         DONE: if (nss_s) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // A final data rise seen together with NSS rising still completes the frame.
      if (nss_s && busy && !(state_q == DATA && rise && last)) begin
         state_d = IDLE;
         addr_d  = addr_q;
         miso_d  = 1'b0;
         write_d = 1'b0;
         abort_d = abort_q + {7'd0, abort_q != 8'hFF};
      end
   end
   assign bus.SPI_MISO_OUT    = miso_q;
   assign bus.WRITE_OUT       = write_q;
   assign bus.ADDR_OUT        = addr_q;
   assign bus.WRITE_DATA_OUT  = wdata_q;
   assign bus.BUSY_OUT        = busy;
   assign bus.ABORT_COUNT_OUT = abort_q;
endmodule

// File: tb/tb_spi_reg_access.sv
// tb_spi_reg_access: directed self-checking bench for spi_reg_access
module tb_spi_reg_access;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          errors = 0;
   int          checks = 0;
   int          strobes = 0;
   int          s0;
   logic [13:0] st_addr = '0;
   logic [31:0] st_data = '0;
   logic [63:0] rx;
   always #5 clk = ~clk;
   spi_reg_access_if #(.REGA_BITS(14), .REGD_BITS(32)) bus ();
   spi_reg_access #(.REGA_BITS(14), .REGD_BITS(32)) dut (
      .CLK_IN(clk),
      .RESET_IN(rst),
      .bus(bus)
   );
   assign bus.READ_DATA_IN = (bus.ADDR_OUT == 14'd2) ? 32'h1234_5678 : {18'd0, bus.ADDR_OUT} ^ 32'hC0DE_0000;
   always @(negedge clk) if (bus.WRITE_OUT) begin
      strobes++;
      st_addr = bus.ADDR_OUT;
      st_data = bus.WRITE_DATA_OUT;
   end
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic logic [63:0] frm(input logic w, input logic b14, input logic [13:0] a,
                                       input logic [31:0] d, input logic [15:0] ext);
      return {w, b14, a, d, ext};
   endfunction
   task automatic spi(input logic [63:0] bits, input int n, input int rst_at, output logic [63:0] r);
      r = '0;
      bus.SPI_NSS_IN = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < n; i++) begin
         bus.SPI_MOSI_IN = bits[63-i];
         if (i == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("rst_write", bus.WRITE_OUT, 0);
            check("rst_addr", bus.ADDR_OUT, 0);
            check("rst_wdata", bus.WRITE_DATA_OUT, 0);
            check("rst_miso", bus.SPI_MISO_OUT, 0);
            check("rst_busy", bus.BUSY_OUT, 0);
            check("rst_abort", bus.ABORT_COUNT_OUT, 0);
         end
         repeat (6) @(negedge clk);
         bus.SPI_SCLK_IN = 1'b1;
         r = {r[62:0], bus.SPI_MISO_OUT};
         repeat (6) @(negedge clk);
         bus.SPI_SCLK_IN = 1'b0;
      end
      repeat (6) @(negedge clk);
      bus.SPI_NSS_IN = 1'b1;
      repeat (8) @(negedge clk);
   endtask
   initial begin
      bus.SPI_NSS_IN = 1'b1;
      bus.SPI_SCLK_IN = 1'b0;
      bus.SPI_MOSI_IN = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_write", bus.WRITE_OUT, 0);
      check("reset_addr", bus.ADDR_OUT, 0);
      check("reset_wdata", bus.WRITE_DATA_OUT, 0);
      check("reset_miso", bus.SPI_MISO_OUT, 0);
      check("reset_busy", bus.BUSY_OUT, 0);
      check("reset_abort", bus.ABORT_COUNT_OUT, 0);
      repeat (10) @(negedge clk);
      s0 = strobes;
      spi(frm(1'b1, 1'b0, 14'd5, 32'hA5A5_0F0F, 16'd0), 48, -1, rx);
      check("wr_strobes", strobes - s0, 1);
      check("wr_st_addr", st_addr, 14'd5);
      check("wr_st_data", st_data, 32'hA5A5_0F0F);
      check("wr_addr_hold", bus.ADDR_OUT, 14'd5);
      check("wr_data_hold", bus.WRITE_DATA_OUT, 32'hA5A5_0F0F);
      check("wr_abort", bus.ABORT_COUNT_OUT, 0);
      check("wr_miso_zero", rx, 0);
      check("wr_busy_after", bus.BUSY_OUT, 0);
      s0 = strobes;
      spi(frm(1'b0, 1'b0, 14'd2, 32'd0, 16'd0), 48, -1, rx);
      check("rd_data", rx[31:0], 32'h1234_5678);
      check("rd_hdr_miso", rx[47:32], 0);
      check("rd_no_strobe", strobes - s0, 0);
      check("rd_miso_idle", bus.SPI_MISO_OUT, 0);
      check("rd_addr", bus.ADDR_OUT, 14'd2);
      s0 = strobes;
      spi(frm(1'b1, 1'b0, 14'd3, 32'hFFFF_0000, 16'd0), 20, -1, rx);
      check("ab_no_strobe", strobes - s0, 0);
      check("ab_count", bus.ABORT_COUNT_OUT, 1);
      check("ab_addr_keep", bus.ADDR_OUT, 14'd3);
      spi(frm(1'b1, 1'b0, 14'd3, 32'hFFFF_0000, 16'd0), 48, -1, rx);
      check("ab_retry_strobe", strobes - s0, 1);
      check("ab_retry_data", st_data, 32'hFFFF_0000);
      check("ab_retry_addr", st_addr, 14'd3);
      check("ab_retry_count", bus.ABORT_COUNT_OUT, 1);
      s0 = strobes;
      spi(frm(1'b1, 1'b0, 14'd4, 32'h3C3C_9696, 16'hFFFF), 60, -1, rx);
      check("ol_strobes", strobes - s0, 1);
      check("ol_st_data", st_data, 32'h3C3C_9696);
      check("ol_st_addr", st_addr, 14'd4);
      check("ol_wdata_hold", bus.WRITE_DATA_OUT, 32'h3C3C_9696);
      check("ol_abort", bus.ABORT_COUNT_OUT, 1);
      s0 = strobes;
      spi(frm(1'b1, 1'b0, 14'd6, 32'hDEAD_BEEF, 16'd0), 48, 30, rx);
      check("rm_no_strobe", strobes - s0, 0);
      check("rm_addr", bus.ADDR_OUT, 0);
      check("rm_abort", bus.ABORT_COUNT_OUT, 0);
      spi(frm(1'b1, 1'b0, 14'd7, 32'h0123_4567, 16'd0), 48, -1, rx);
      check("rm_clean_strobe", strobes - s0, 1);
      check("rm_clean_data", st_data, 32'h0123_4567);
      check("rm_clean_addr", st_addr, 14'd7);
      for (int i = 0; i < 255; i++) spi(64'd0, 1, -1, rx);
      check("sat_255", bus.ABORT_COUNT_OUT, 255);
      for (int i = 0; i < 5; i++) spi(64'd0, 1, -1, rx);
      check("sat_260", bus.ABORT_COUNT_OUT, 255);
      s0 = strobes;
      spi(frm(1'b1, 1'b1, 14'd1, 32'h0BAD_F00D, 16'd0), 48, -1, rx);
      check("b14_strobe", strobes - s0, 1);
      check("b14_addr", bus.ADDR_OUT, 14'd1);
      check("b14_data", st_data, 32'h0BAD_F00D);
      check("b14_abort", bus.ABORT_COUNT_OUT, 255);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/spi_reg_access.md
# spi_reg_access

SPI slave that turns framed serial commands from the board controller into single-cycle register reads and writes on the top-level control/diagnostic register bank. It sits directly upstream of the register bank, driving its write strobe, address and write data, and returning its combinational read data on MISO. All SPI pins are treated as asynchronous and are oversampled in the system clock domain; no SCLK-domain logic exists.

## Interface
Parameters:
- REGA_BITS, 14, register address width; must be ≤ 15.
- REGD_BITS, 32, register data width; frame length is 16 + REGD_BITS bits.

Ports:
- Clocking: one clock, CLK_IN. Reset is RESET_IN, synchronous and active-high.
- CLK_IN  in  1  system clock; must be ≥ 8× SCLK frequency.
- RESET_IN  in  1  synchronous active-high reset.
- SPI_NSS_IN  in  1  async chip select, active-low.
- SPI_SCLK_IN  in  1  async SPI clock, mode 0 (CPOL=0, CPHA=0).
- SPI_MOSI_IN  in  1  async serial data in, MSB first.
- SPI_MISO_OUT  out  1  serial read data, MSB first.
- WRITE_OUT  out  1  one-cycle register write strobe.
- ADDR_OUT  out  REGA_BITS  register address.
- WRITE_DATA_OUT  out  REGD_BITS  register write data.
- READ_DATA_IN  in  REGD_BITS  register read data for ADDR_OUT (combinational in bank).
- BUSY_OUT  out  1  high while a frame is in progress (NSS low, not yet complete).
- ABORT_COUNT_OUT  out  8  saturating count of frames cut short by NSS rising.

## Operation
- Each of NSS, SCLK and MOSI passes through a 2-flop synchroniser. A third SCLK flop gives rise/fall detection: rise = sync & ~prev; fall = ~sync & prev.
- Frame: bit 15 = W (1 write, 0 read); bit 14 and bits 13:REGA_BITS ignored; bits REGA_BITS-1:0 = address; followed by REGD_BITS data bits.
- States:
  - IDLE: wait for synced NSS low, then clear the bit counter and go to HDR.
  - HDR: shift MOSI into the header on each SCLK rise. On the 16th rise, ADDR_OUT <= header address and latch W. Go to LOAD if W=0, else DATA.
  - LOAD: one cycle. Read shift register <= READ_DATA_IN (ADDR_OUT is already stable). Go to DATA.
  - DATA: a write shifts MOSI into WRITE_DATA_OUT on each rise. A read updates MISO on each SCLK fall: MISO <= rdsh[MSB], rdsh <= rdsh << 1. After the REGD_BITS-th data rise go to DONE. If W, pulse WRITE_OUT on the cycle of entry to DONE.
  - DONE: ignore further SCLK edges and hold MISO; return to IDLE when synced NSS goes high.
- NSS high in HDR, LOAD or DATA aborts the frame:
  - go to IDLE, no WRITE_OUT;
  - ABORT_COUNT_OUT increments, saturating at 255;
  - ADDR_OUT keeps its last value.
- Reads have no side effects. A read and a write may address any value; unmapped addresses are the bank's concern.
- MISO is 0 in IDLE, HDR and write frames.

## Timing
- Reset values: state IDLE, WRITE_OUT 0, ADDR_OUT 0, WRITE_DATA_OUT 0, MISO 0, BUSY_OUT 0, ABORT_COUNT_OUT 0. Synchroniser flops reset to NSS=1, SCLK=0, MOSI=0.
- Edge-detect latency is 3 CLK_IN cycles from the pin transition; all SPI-derived actions are relative to the detected edge.
- ADDR_OUT is registered 1 cycle after the 16th detected rise. READ_DATA_IN is sampled in LOAD, 1 cycle later. This is well before the 16th detected fall, given the ≥8× oversampling.
- The first read bit appears on MISO 1 cycle after the 16th detected fall (the fall following the last header bit). It is valid before the first data rise.
- WRITE_OUT is high for exactly 1 cycle, 1 cycle after the last data rise. WRITE_DATA_OUT and ADDR_OUT are stable during and after the strobe until the next frame's corresponding phase.
- BUSY_OUT rises 1 cycle after synced NSS falls. It drops on entry to DONE or IDLE.
- Reset asserted mid-frame returns to IDLE with the values above on the next edge, with no strobe. A frame already in progress at reset release is ignored until NSS goes high, then low again (entry to HDR needs an IDLE→NSS-low transition).
- NSS rise and the final data rise detected in the same cycle: the frame completes (write strobes) and no abort is counted.

## Test plan
- Write: frame W=1, addr 0x0005, data 0xA5A5_0F0F -> WRITE_OUT high 1 cycle, ADDR_OUT=5, WRITE_DATA_OUT=0xA5A50F0F, ABORT_COUNT_OUT unchanged.
- Read: READ_DATA_IN model returns 0x1234_5678 when ADDR_OUT=2; read frame addr 2 -> MISO bits 0x12345678 MSB first, WRITE_OUT never high.
- Abort: write frame addr 3, NSS high after 20 bits -> no WRITE_OUT, ABORT_COUNT_OUT=1, next full write to addr 3 data 0xFFFF_0000 succeeds.
- Overlong frame: 60 SCLK cycles on a write to addr 4 -> exactly one strobe with the first 32 data bits; extra bits ignored, no abort.
- Reset mid-frame: RESET_IN for 1 cycle at bit 30 of a write -> all outputs at reset values, no strobe, then a clean frame works.
- Saturation: 260 aborted frames -> ABORT_COUNT_OUT=255; header bit 14 set on a write to 0x0001 -> ADDR_OUT=1.
